// File: rtl/alu_exec_unit.sv
// Integer ALU execute stage: single-cycle RV32I ALU feeding a small in-order
// result queue that drains onto the CDB through a request/grant handshake.

package alu_exec_pkg;

   parameter int unsigned XLEN  = 32;
   parameter int unsigned TAG_W = 6;

   typedef enum logic [3:0] {
      OpAdd   = 4'd0,
      OpSub   = 4'd1,
      OpSll   = 4'd2,
      OpSlt   = 4'd3,
      OpSltu  = 4'd4,
      OpXor   = 4'd5,
      OpSrl   = 4'd6,
      OpSra   = 4'd7,
      OpOr    = 4'd8,
      OpAnd   = 4'd9,
      OpPassB = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic            ready;
      logic [XLEN-1:0] data;
   } operand_t;

   typedef struct packed {
      logic             is_valid;
      logic [3:0]       alu_op;
      logic [TAG_W-1:0] dest_tag;
      operand_t         src_0_a;
      operand_t         src_0_b;
   } instruction_t;

   typedef struct packed {
      logic             is_valid;
      logic [TAG_W-1:0] dest_tag;
      logic [XLEN-1:0]  result;
   } writeback_packet_t;

endpackage

module alu_exec_unit
   import alu_exec_pkg::*;
#(
   // Must be a power of two so the pointers wrap naturally.
   parameter int unsigned RESULT_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  instruction_t      execute_pkt,
   output logic              alu_re,
   output logic              cdb_req,
   input  logic              cdb_grant,
   output writeback_packet_t wb_pkt
);

   localparam int unsigned PtrW = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
   localparam int unsigned CntW = $clog2(RESULT_DEPTH + 1);
   localparam int unsigned ShW  = $clog2(XLEN);

   localparam logic [CntW-1:0] CntFull = CntW'(RESULT_DEPTH);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

   logic [XLEN-1:0]  res_mem_q [RESULT_DEPTH];
   logic [TAG_W-1:0] tag_mem_q [RESULT_DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;

   logic            accept;
   logic            pop;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [ShW-1:0]  shamt;
   logic [XLEN-1:0] alu_result;

   // Operand readiness is guaranteed upstream, so the ready bits are ignored.
   logic unused_ready;
   assign unused_ready = execute_pkt.src_0_a.ready ^ execute_pkt.src_0_b.ready;

   // alu_re depends only on registered state and flush, never on cdb_grant.
   assign alu_re  = (count_q != CntFull) && !flush;
   assign cdb_req = (count_q != '0);
   assign accept  = execute_pkt.is_valid && alu_re;
   assign pop     = cdb_req && cdb_grant;

   assign op_a  = execute_pkt.src_0_a.data;
   assign op_b  = execute_pkt.src_0_b.data;
   assign shamt = op_b[ShW-1:0];

   // Single-cycle integer result; undefined opcodes yield zero but still write back.
   always_comb begin
      alu_result = '0;
      case (execute_pkt.alu_op)
         OpAdd:   alu_result = op_a + op_b;
         OpSub:   alu_result = op_a - op_b;
         OpSll:   alu_result = op_a << shamt;
         OpSlt:   alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
         OpSltu:  alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
         OpXor:   alu_result = op_a ^ op_b;
         OpSrl:   alu_result = op_a >> shamt;
         OpSra:   alu_result = $unsigned($signed(op_a) >>> shamt);
         OpOr:    alu_result = op_a | op_b;
         OpAnd:   alu_result = op_a & op_b;
         OpPassB: alu_result = op_b;
         default: alu_result = '0;
      endcase
   end

   // Queue pointer and occupancy update; flush discards any same-cycle push or pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (accept) wr_ptr_d = wr_ptr_q + PtrOne;
         if (pop)    rd_ptr_d = rd_ptr_q + PtrOne;
         case ({accept, pop})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
         endcase
      end
   end

   // Queue control state, cleared asynchronously so reset drops all entries.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Result storage; contents are only visible while count is non-zero.
   always_ff @(posedge clk) begin
      if (accept) begin
         res_mem_q[wr_ptr_q] <= alu_result;
         tag_mem_q[wr_ptr_q] <= execute_pkt.dest_tag;
      end
   end

   // Head entry toward the CDB, forced to zero when the queue is empty.
   always_comb begin
      wb_pkt = '0;
      if (cdb_req) begin
         wb_pkt.is_valid = 1'b1;
         wb_pkt.dest_tag = tag_mem_q[rd_ptr_q];
         wb_pkt.result   = res_mem_q[rd_ptr_q];
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus random
// traffic, compared against a queue-based behavioural model.

module tb_alu_exec_unit;
   import alu_exec_pkg::*;

   localparam int unsigned Depth = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              flush = 1'b0;
   logic              cdb_grant = 1'b0;
   instruction_t      execute_pkt = '0;
   logic              alu_re;
   logic              cdb_req;
   writeback_packet_t wb_pkt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [37:0] exp_q  [$];   // {dest_tag, result}, head first
   logic [5:0]  seen_q [$];   // tags that actually crossed the CDB

   always #5 clk = ~clk;

   alu_exec_unit #(
      .RESULT_DEPTH(Depth)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .execute_pkt(execute_pkt),
      .alu_re     (alu_re),
      .cdb_req    (cdb_req),
      .cdb_grant  (cdb_grant),
      .wb_pkt     (wb_pkt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference ALU from the opcode table, computed with wide signed arithmetic.
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int unsigned sh;
      longint      sa;
      longint      sb;
      sh = b % 32;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a << sh;
         4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd4:    return (a < b) ? 32'd1 : 32'd0;
         4'd5:    return a ^ b;
         4'd6:    return a >> sh;
         4'd7:    return 32'(sa >>> sh);
         4'd8:    return a | b;
         4'd9:    return a & b;
         4'd10:   return b;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 3))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // One clock: drive inputs, check outputs against the model mid-cycle, advance model.
   task automatic cycle(input logic v, input logic [3:0] op, input logic [5:0] tag,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic g, input logic f);
      logic        exp_re;
      logic        exp_req;
      logic [38:0] exp_wb;
      execute_pkt               = '0;
      execute_pkt.is_valid      = v;
      execute_pkt.alu_op        = op;
      execute_pkt.dest_tag      = tag;
      execute_pkt.src_0_a.ready = 1'b1;
      execute_pkt.src_0_a.data  = a;
      execute_pkt.src_0_b.ready = 1'b1;
      execute_pkt.src_0_b.data  = b;
      cdb_grant                 = g;
      flush                     = f;
      @(negedge clk);
      exp_req = (exp_q.size() != 0);
      exp_re  = (exp_q.size() != Depth) && !f;
      exp_wb  = exp_req ? {1'b1, exp_q[0]} : 39'd0;
      check("cdb_req", 64'(cdb_req), 64'(exp_req));
      check("alu_re", 64'(alu_re), 64'(exp_re));
      check("wb_pkt", 64'(wb_pkt), 64'(exp_wb));
      if (cdb_req && g && !f) seen_q.push_back(wb_pkt.dest_tag);
      if (f) begin
         exp_q.delete();
      end else begin
         if (exp_req && g) void'(exp_q.pop_front());
         if (v && exp_re) exp_q.push_back({tag, ref_alu(op, a, b)});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic g);
      cycle(1'b0, 4'd0, 6'd0, 32'd0, 32'd0, g, 1'b0);
   endtask

   logic [3:0]  sw_op  [10] = '{4'd1, 4'd3, 4'd4, 4'd7, 4'd2, 4'd0, 4'd5, 4'd10, 4'd12, 4'd9};
   logic [31:0] sw_a   [10] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
                                32'hFFFF_FFFF, 32'hF0F0_0000, 32'd7, 32'd9, 32'hFF00_FF00};
   logic [31:0] sw_b   [10] = '{32'd7, 32'd1, 32'd1, 32'd4, 32'd33,
                                32'd2, 32'h0FF0_0000, 32'hABCD_0123, 32'd9, 32'h0FF0_0FF0};
   logic [31:0] sw_exp [10] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hF800_0000, 32'd2,
                                32'd1, 32'hFF00_0000, 32'hABCD_0123, 32'd0, 32'h0F00_0F00};

   initial begin
      int hits;

      // Reset state
      #1;
      check("rst_req", 64'(cdb_req), 64'(0));
      check("rst_wb", 64'(wb_pkt), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("rel_re", 64'(alu_re), 64'(1));

      // Op sweep with grant always high: each result is the head one cycle later
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, sw_op[i], 6'(10 + i), sw_a[i], sw_b[i], 1'b1, 1'b0);
         check("sweep_valid", 64'(wb_pkt.is_valid), 64'(1));
         check("sweep_tag", 64'(wb_pkt.dest_tag), 64'(10 + i));
         check("sweep_res", 64'(wb_pkt.result), 64'(sw_exp[i]));
      end
      idle(1'b1);

      // Backpressure: tags 3,4,5 with grant low, then drain
      seen_q.delete();
      cycle(1'b1, 4'd0, 6'd3, 32'd1, 32'd2, 1'b0, 1'b0);
      cycle(1'b1, 4'd0, 6'd4, 32'd3, 32'd4, 1'b0, 1'b0);
      check("bp_full", 64'(alu_re), 64'(0));
      cycle(1'b1, 4'd0, 6'd5, 32'd5, 32'd6, 1'b0, 1'b0);
      check("bp_hold_tag", 64'(wb_pkt.dest_tag), 64'(3));
      cycle(1'b1, 4'd0, 6'd5, 32'd5, 32'd6, 1'b1, 1'b0);
      check("bp_reopen", 64'(alu_re), 64'(1));
      cycle(1'b1, 4'd0, 6'd5, 32'd5, 32'd6, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      check("bp_count", 64'(seen_q.size()), 64'(3));
      for (int i = 0; i < 3; i++) begin
         if (i < seen_q.size()) check("bp_order", 64'(seen_q[i]), 64'(3 + i));
      end

      // Simultaneous push and pop at count 1, enough times to wrap the pointers
      cycle(1'b1, 4'd0, 6'd20, 32'd20, 32'd0, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         cycle(1'b1, 4'($urandom_range(0, 15)), 6'(21 + k), rand_word(), rand_word(),
               1'b1, 1'b0);
         check("pp_req", 64'(cdb_req), 64'(1));
         check("pp_re", 64'(alu_re), 64'(1));
         check("pp_tag", 64'(wb_pkt.dest_tag), 64'(21 + k));
      end
      idle(1'b1);

      // Flush with two entries queued plus an accept and a grant in the flush cycle
      seen_q.delete();
      cycle(1'b1, 4'd0, 6'd30, 32'd1, 32'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'd0, 6'd31, 32'd2, 32'd2, 1'b0, 1'b0);
      cycle(1'b1, 4'd0, 6'd32, 32'd3, 32'd3, 1'b1, 1'b1);
      flush = 1'b0;
      execute_pkt.is_valid = 1'b0;
      #1;
      check("fl_req", 64'(cdb_req), 64'(0));
      check("fl_re", 64'(alu_re), 64'(1));
      check("fl_wb", 64'(wb_pkt), 64'(0));
      repeat (3) idle(1'b1);
      hits = 0;
      foreach (seen_q[i]) if (seen_q[i] >= 6'd30 && seen_q[i] <= 6'd32) hits++;
      check("fl_stale", 64'(hits), 64'(0));

      // Spurious grant on an empty queue must not move the read pointer
      idle(1'b1);
      idle(1'b1);
      check("sp_valid", 64'(wb_pkt.is_valid), 64'(0));
      cycle(1'b1, 4'd0, 6'd40, 32'd100, 32'd23, 1'b0, 1'b0);
      check("sp_tag", 64'(wb_pkt.dest_tag), 64'(40));
      check("sp_res", 64'(wb_pkt.result), 64'(123));
      idle(1'b1);

      // Random traffic
      for (int n = 0; n < 500; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
               6'($urandom_range(0, 63)), rand_word(), rand_word(),
               1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
      end

      // Asynchronous reset mid-drain with two entries queued
      cycle(1'b1, 4'd0, 6'd50, 32'd1, 32'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'd0, 6'd51, 32'd1, 32'd1, 1'b0, 1'b0);
      cycle(1'b1, 4'd0, 6'd52, 32'd1, 32'd1, 1'b0, 1'b0);
      execute_pkt.is_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check("ar_req", 64'(cdb_req), 64'(0));
      check("ar_wb", 64'(wb_pkt), 64'(0));
      exp_q.delete();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      check("ar_re", 64'(alu_re), 64'(1));
      idle(1'b1);
      idle(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Integer ALU execute stage sitting directly downstream of the single-entry ALU reservation station. Accepts a ready instruction packet when it asserts `alu_re`, computes the RV32I integer result in one cycle, and buffers results in a small in-order result queue. The queue drains onto the common data bus through a request/grant handshake with the CDB arbiter, so CDB backpressure stalls the reservation station without losing results.

## Interface
- `XLEN`, 32: datapath width.
- `RESULT_DEPTH`, 2: result queue entries; power of two, ≥2.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `flush`  in  1  synchronous squash of all in-flight work.
- `execute_pkt`  in  instruction_t  from the RS; uses `is_valid`, `alu_op[3:0]`, `dest_tag`, `src_0_a.data`, `src_0_b.data`.
- `alu_re`  out  1  ready-to-accept, returned to the RS.
- `cdb_req`  out  1  request for a CDB slot.
- `cdb_grant`  in  1  arbiter grant for this cycle.
- `wb_pkt`  out  writeback_packet_t  `is_valid`, `dest_tag`, `result` toward the CDB.

## Operation
- Accept: `accept = execute_pkt.is_valid && alu_re && !flush`. Operand readiness is the RS's responsibility; no source checks here.
- `alu_re = (count != RESULT_DEPTH) && !flush`, from registered state and `flush` only. No combinational path from `cdb_grant`.
- `alu_op` encoding, with a = `src_0_a.data`, b = `src_0_b.data`:
  - 0 ADD a+b, 1 SUB a−b, 2 SLL a<<b[4:0], 3 SLT signed a<b, 4 SLTU unsigned a<b, 5 XOR, 6 SRL logical a>>b[4:0], 7 SRA arithmetic a>>>b[4:0], 8 OR, 9 AND, 10 PASSB b.
  - 11–15: result 0; the entry is still written back.
  - ADD/SUB wrap modulo 2^XLEN. SLT/SLTU produce 0 or 1, zero-extended.
- On accept, `{dest_tag, result}` is written to the queue at `wr_ptr` in the same edge.
- Queue: circular buffer with `wr_ptr`, `rd_ptr` (log2 depth, wrap naturally), and `count` (0..DEPTH).
- `cdb_req = (count != 0)`.
- `wb_pkt` is the head entry, with `wb_pkt.is_valid = cdb_req`. It is 0 when the queue is empty.
- Pop when `cdb_req && cdb_grant`. A grant with no request is ignored.
- Push and pop in the same edge: both pointers advance and `count` is unchanged. This is legal only when not full on entry, because `alu_re` is low when full.
- Flush: at the next edge clear `count`, `wr_ptr`, `rd_ptr`. Any accept or pop in that cycle is discarded. `cdb_req` is still driven from the current state during the flush cycle; the arbiter gates it with flush.
- Reset (asynchronous, `rst`=0): `count`/pointers = 0, `cdb_req`=0, `wb_pkt`=0, `alu_re`=1 after release. Reset mid-drain drops all entries.

## Timing
- Latency: packet accepted at edge t appears on `wb_pkt` with `cdb_req`=1 in the cycle after t, provided it is at the queue head.
- Throughput: 1 op/cycle while `cdb_grant` is held high continuously.
- Full at depth 2 with no grants: `alu_re` drops the cycle after the 2nd accept. It rises the cycle after the first granted pop.
- Result order on the CDB equals accept order. No bypass around the queue.
- `wb_pkt` and `cdb_req` hold stable while requested and not granted.

## Test plan
- Reset/idle: `rst`=0 mid-operation with 2 queued entries -> immediately `cdb_req`=0 and `wb_pkt`=0; after release `alu_re`=1.
- Op sweep, grant always 1: SUB 5−7 -> 0xFFFFFFFE; SLT 0xFFFFFFFF<1 -> 1; SLTU 0xFFFFFFFF<1 -> 0; SRA 0x80000000>>>4 -> 0xF8000000; SLL 1<<33 -> 2. Each result appears one cycle after accept with the correct `dest_tag`.
- Backpressure: grant held 0, three back-to-back packets with tags 3,4,5 -> tags 3 and 4 accepted, `alu_re`=0 while tag 5 waits. Grant raised -> the CDB sees 3,4,5 in order with no loss or duplication.
- Simultaneous push/pop: count=1 with grant=1 and accept in the same cycle -> count stays 1, and the next head is the new entry. Repeat 10× to exercise pointer wrap.
- Flush: 2 entries queued plus an accept in the flush cycle -> the next cycle has count=0, `cdb_req`=0, `alu_re`=1, and no stale tag ever reaches the CDB.
- Spurious grant: `cdb_grant`=1 with an empty queue -> no pointer movement, and `wb_pkt.is_valid` stays 0.
